// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame-level sequencer for a bit-serial 1011 detector.
// Accepts WIDTH-bit words over valid/ready, shifts them MSB-first onto det_x
// while det_en is high, counts detector hits over a frame, and reports the
// per-frame match count with a one-cycle match_valid pulse.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   in_valid/in_ready     word handshake; in_data/in_last sampled on transfer
//   det_x, det_en         serial bit and clock enable to the detector
//   det_clr               one-cycle synchronous clear of the detector
//   det_z                 detector Moore output
//   match_count, overflow last frame's result, held until the next report
//   match_valid           pulse marking a new match_count/overflow
module seq_scan_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             det_x,
   output logic             det_en,
   output logic             det_clr,
   input  logic             det_z,
   output logic [CNT_W-1:0] match_count,
   output logic             match_valid,
   output logic             overflow
);

   localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {StIdle, StShift, StDrain, StReport} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               last_q, last_d;
   logic               en_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               frame_ovf_q, frame_ovf_d;
   logic [CNT_W-1:0]   match_count_q;
   logic               overflow_q;
   logic               final_bit;
   logic               hit;

   assign final_bit = (idx_q == IDX_LAST);

   // en_q marks cycles whose det_z reflects a bit consumed on the previous edge.
   assign hit = en_q & det_z;

   // Sequencing and handshake. in_ready depends only on state and index.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      idx_d       = idx_q;
      last_d      = last_q;
      in_ready    = 1'b0;
      det_en      = 1'b0;
      det_x       = 1'b0;
      det_clr     = 1'b0;
      match_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shreg_d = in_data;
               last_d  = in_last;
               idx_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            det_en  = 1'b1;
            det_x   = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q + 1'b1;
            if (final_bit) begin
               if (last_q) begin
                  state_d = StDrain;
               end else begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     // Gapless reload: next word's MSB goes out next cycle.
                     shreg_d = in_data;
                     last_d  = in_last;
                     idx_d   = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         StDrain: begin
            // Detector idle for one cycle so the final bit's det_z is counted.
            state_d = StReport;
         end
         StReport: begin
            det_clr     = 1'b1;
            match_valid = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Saturating hit counter with sticky frame overflow.
   always_comb begin
      cnt_d       = cnt_q;
      frame_ovf_d = frame_ovf_q;
      if (state_q == StReport) begin
         cnt_d       = '0;
         frame_ovf_d = 1'b0;
      end else if (hit) begin
         if (cnt_q == CNT_MAX) begin
            frame_ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         shreg_q       <= '0;
         idx_q         <= '0;
         last_q        <= 1'b0;
         en_q          <= 1'b0;
         cnt_q         <= '0;
         frame_ovf_q   <= 1'b0;
         match_count_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         en_q        <= det_en;
         cnt_q       <= cnt_d;
         frame_ovf_q <= frame_ovf_d;
         // Capture the final tally (including the DRAIN hit) on the DRAIN edge
         // so the result is visible throughout the REPORT cycle.
         if (state_q == StDrain) begin
            match_count_q <= cnt_d;
            overflow_q    <= frame_ovf_d;
         end
      end
   end

   assign match_count = match_count_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl. A behavioural 1011 detector drives
// det_z; expected frame results come from a sliding-window count over the
// planned frame bits.
module tb_seq_scan_ctrl;

   localparam int W    = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, det_x, det_en, det_clr, det_z, match_valid, overflow;
   logic [CW-1:0] match_count;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Monitor records
   int xfer_cyc[$];
   int en_cyc[$];
   bit bits_q[$];
   int rep_cyc[$];
   int rep_cnt[$];
   bit rep_ovf[$];
   int hs_bad, clr_n, clr_bad;
   bit prev_ready;

   // Reference model state
   bit plan_bits[$];
   bit frame_bits[$];
   int exp_n[$];

   logic [3:0] hist;

   seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .det_x       (det_x),
      .det_en      (det_en),
      .det_clr     (det_clr),
      .det_z       (det_z),
      .match_count (match_count),
      .match_valid (match_valid),
      .overflow    (overflow)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural overlapping 1011 Moore detector.
   always @(posedge clk or posedge reset) begin
      if (reset)        hist <= '0;
      else if (det_clr) hist <= '0;
      else if (det_en)  hist <= {hist[2:0], det_x};
   end
   assign det_z = (hist == 4'b1011);

   always @(negedge clk) begin
      if (!reset) begin
         if (in_valid && in_ready) xfer_cyc.push_back(cyc);
         if (det_en) begin
            bits_q.push_back(det_x);
            en_cyc.push_back(cyc);
         end
         if (match_valid) begin
            rep_cyc.push_back(cyc);
            rep_cnt.push_back(int'(match_count));
            rep_ovf.push_back(overflow);
            if (in_ready || prev_ready) hs_bad++;
         end
         if (det_clr) clr_n++;
         if (det_clr != match_valid) clr_bad++;
      end
      prev_ready = in_ready;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish, time %0t want < 2000000", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic void plan_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) begin
         plan_bits.push_back(w[i]);
         frame_bits.push_back(w[i]);
      end
   endfunction

   function automatic void plan_end_frame();
      int n = 0;
      for (int i = 0; i + 3 < frame_bits.size(); i++)
         if (frame_bits[i] && !frame_bits[i+1] && frame_bits[i+2] && frame_bits[i+3]) n++;
      exp_n.push_back(n);
      frame_bits.delete();
   endfunction

   function automatic int exp_cnt(input int n);
      return (n > CMAX) ? CMAX : n;
   endfunction

   function automatic int exp_ovf(input int n);
      return (n > CMAX) ? 1 : 0;
   endfunction

   function automatic bit bits_match();
      if (bits_q.size() != plan_bits.size()) return 1'b0;
      foreach (bits_q[i]) if (bits_q[i] != plan_bits[i]) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic start_test();
      in_valid = 1'b0;
      xfer_cyc.delete(); en_cyc.delete(); bits_q.delete();
      rep_cyc.delete(); rep_cnt.delete(); rep_ovf.delete();
      hs_bad = 0; clr_n = 0; clr_bad = 0;
      plan_bits.delete(); frame_bits.delete(); exp_n.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
   task automatic send_word(input logic [W-1:0] d, input logic l);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         $display("FAIL send_timeout in_ready got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_reports(input int n, output bit ok);
      int t = 0;
      while (rep_cyc.size() < n && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      ok = (rep_cyc.size() >= n);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
      else n_pass++;
      n_checks++;
      if ({det_x, det_en, det_clr, match_valid, overflow} !== 5'b0)
         $display("FAIL reset_outputs got %b want 00000",
                  {det_x, det_en, det_clr, match_valid, overflow});
      else n_pass++;
      n_checks++;
      if (match_count !== '0) $display("FAIL reset_count got %0d want 0", match_count);
      else n_pass++;
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_single_word();
      bit ok; int n;
      start_test();
      plan_word(8'b1011_0110); plan_end_frame();
      send_word(8'b1011_0110, 1'b1);
      wait_reports(1, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL single_report got %0d reports want 1", rep_cyc.size());
      else n_pass++;
      n_checks++;
      if (bits_match() !== 1'b1) $display("FAIL single_bits got %0d bits want 8 matching", bits_q.size());
      else n_pass++;
      n = (ok && xfer_cyc.size() > 0) ? rep_cyc[0] - xfer_cyc[0] : -1;
      n_checks++;
      if (n != 10) $display("FAIL single_latency got %0d want 10", n);
      else n_pass++;
      n = ok ? rep_cnt[0] : -1;
      n_checks++;
      if (n != exp_cnt(exp_n[0])) $display("FAIL single_count got %0d want %0d", n, exp_cnt(exp_n[0]));
      else n_pass++;
      n = ok ? int'(rep_ovf[0]) : -1;
      n_checks++;
      if (n != 0) $display("FAIL single_ovf got %0d want 0", n);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok; int n;
      start_test();
      send_word(8'b1011_0110, 1'b0);
      idle(5);  // now in the cycle driving bit 5
      reset = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready);
      else n_pass++;
      n_checks++;
      if ({det_x, det_en, det_clr, match_valid, overflow, match_count} !== '0)
         $display("FAIL rstmid_outputs got %b want 0",
                  {det_x, det_en, det_clr, match_valid, overflow, match_count});
      else n_pass++;
      idle(2);
      reset = 1'b0;
      start_test();
      idle(12);
      n_checks++;
      if (rep_cyc.size() + en_cyc.size() != 0)
         $display("FAIL rstmid_quiet got %0d reports %0d enables want 0 0", rep_cyc.size(), en_cyc.size());
      else n_pass++;
      plan_word(8'b1011_0000); plan_end_frame();
      send_word(8'b1011_0000, 1'b1);
      wait_reports(1, ok);
      n = ok ? rep_cnt[0] : -1;
      n_checks++;
      if (n != exp_cnt(exp_n[0])) $display("FAIL rstmid_count got %0d want %0d", n, exp_cnt(exp_n[0]));
      else n_pass++;
   endtask

   task automatic test_cross_word();
      bit ok; int n;
      start_test();
      plan_word(8'b0000_0101); plan_word(8'b1000_0000); plan_end_frame();
      send_word(8'b0000_0101, 1'b0);
      send_word(8'b1000_0000, 1'b1);
      wait_reports(1, ok);
      n = (en_cyc.size() == 16) ? en_cyc[15] - en_cyc[0] : -1;
      n_checks++;
      if (n != 15) $display("FAIL cross_gapless got span %0d want 15", n);
      else n_pass++;
      n = ok ? rep_cnt[0] : -1;
      n_checks++;
      if (n != exp_cnt(exp_n[0])) $display("FAIL cross_count got %0d want %0d", n, exp_cnt(exp_n[0]));
      else n_pass++;
      n = (ok && xfer_cyc.size() > 0) ? rep_cyc[0] - xfer_cyc[0] : -1;
      n_checks++;
      if (n != 18) $display("FAIL cross_latency got %0d want 18", n);
      else n_pass++;
      n_checks++;
      if (bits_match() !== 1'b1) $display("FAIL cross_bits got %0d bits want 16 matching", bits_q.size());
      else n_pass++;
   endtask

   task automatic test_idle_gap();
      bit ok; int n;
      start_test();
      plan_word(8'b0000_0101); plan_word(8'b1000_0000); plan_end_frame();
      send_word(8'b0000_0101, 1'b0);
      idle(11);  // misses the reload slot, then three more idle cycles
      send_word(8'b1000_0000, 1'b1);
      wait_reports(1, ok);
      n = (en_cyc.size() == 16) ? en_cyc[8] - en_cyc[7] - 1 : -1;
      n_checks++;
      if (n != 4) $display("FAIL gap_en_low got %0d cycles want 4", n);
      else n_pass++;
      n = ok ? rep_cnt[0] : -1;
      n_checks++;
      if (n != exp_cnt(exp_n[0])) $display("FAIL gap_count got %0d want %0d", n, exp_cnt(exp_n[0]));
      else n_pass++;
      n = (ok && xfer_cyc.size() > 0) ? rep_cyc[0] - xfer_cyc[0] : -1;
      n_checks++;
      if (n != 22) $display("FAIL gap_latency got %0d want 22", n);
      else n_pass++;
   endtask

   task automatic test_saturation();
      bit ok; int n;
      start_test();
      for (int i = 0; i < 8; i++) plan_word(8'b1011_0110);
      plan_end_frame();
      plan_word(8'h00); plan_end_frame();
      for (int i = 0; i < 8; i++) send_word(8'b1011_0110, (i == 7));
      wait_reports(1, ok);
      send_word(8'h00, 1'b1);
      wait_reports(2, ok);
      n = ok ? rep_cnt[0] : -1;
      n_checks++;
      if (n != exp_cnt(exp_n[0])) $display("FAIL sat_count got %0d want %0d", n, exp_cnt(exp_n[0]));
      else n_pass++;
      n = ok ? int'(rep_ovf[0]) : -1;
      n_checks++;
      if (n != exp_ovf(exp_n[0])) $display("FAIL sat_ovf got %0d want %0d", n, exp_ovf(exp_n[0]));
      else n_pass++;
      n = (ok && xfer_cyc.size() > 0) ? rep_cyc[0] - xfer_cyc[0] : -1;
      n_checks++;
      if (n != 8 * W + 2) $display("FAIL sat_latency got %0d want %0d", n, 8 * W + 2);
      else n_pass++;
      n = ok ? rep_cnt[1] : -1;
      n_checks++;
      if (n != exp_cnt(exp_n[1])) $display("FAIL sat_next_count got %0d want %0d", n, exp_cnt(exp_n[1]));
      else n_pass++;
      n = ok ? int'(rep_ovf[1]) : -1;
      n_checks++;
      if (n != exp_ovf(exp_n[1])) $display("FAIL sat_next_ovf got %0d want %0d", n, exp_ovf(exp_n[1]));
      else n_pass++;
   endtask

   task automatic test_handshake();
      bit ok; int n, k, t, nf, nw, bad;
      logic [W-1:0] d;
      logic [W-1:0] words[$];
      bit lasts[$];
      start_test();
      nf = 3;
      for (int f = 0; f < nf; f++) begin
         nw = $urandom_range(1, 3);
         for (int w = 0; w < nw; w++) begin
            d = W'($urandom);
            words.push_back(d);
            lasts.push_back(w == nw - 1);
            plan_word(d);
         end
         plan_end_frame();
      end
      k = 0; t = 0;
      in_valid = 1'b1;
      while (k < words.size() && t < 500) begin
         if (in_ready) begin
            in_data = words[k]; in_last = lasts[k]; k++;
         end else begin
            in_data = W'($urandom); in_last = 1'($urandom);
         end
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      wait_reports(nf, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL hs_reports got %0d want %0d", rep_cyc.size(), nf);
      else n_pass++;
      bad = 0;
      if (xfer_cyc.size() != words.size()) bad++;
      else for (int i = 1; i < xfer_cyc.size(); i++)
         if (xfer_cyc[i] - xfer_cyc[i-1] != (lasts[i-1] ? W + 3 : W)) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL hs_spacing got %0d bad gaps want 0", bad);
      else n_pass++;
      n_checks++;
      if (hs_bad != 0) $display("FAIL hs_ready_drain_report got %0d want 0", hs_bad);
      else n_pass++;
      n_checks++;
      if (clr_n != nf || clr_bad != 0)
         $display("FAIL hs_det_clr got %0d pulses %0d misaligned want %0d 0", clr_n, clr_bad, nf);
      else n_pass++;
      for (int f = 0; f < nf; f++) begin
         n = (f < rep_cnt.size()) ? rep_cnt[f] : -1;
         n_checks++;
         if (n != exp_cnt(exp_n[f])) $display("FAIL hs_count%0d got %0d want %0d", f, n, exp_cnt(exp_n[f]));
         else n_pass++;
      end
      n_checks++;
      if (bits_match() !== 1'b1) $display("FAIL hs_bits got %0d bits want %0d matching", bits_q.size(), plan_bits.size());
      else n_pass++;
   endtask

   task automatic test_random_gaps();
      bit ok; int n, nf, nw;
      logic [W-1:0] d;
      start_test();
      nf = 4;
      for (int f = 0; f < nf; f++) begin
         nw = $urandom_range(1, 3);
         for (int w = 0; w < nw; w++) begin
            // Bias toward 1011-rich words so counts vary.
            d = ($urandom_range(0, 1) == 1) ? 8'b1011_0110 ^ W'($urandom_range(0, 3)) : W'($urandom);
            plan_word(d);
            idle($urandom_range(0, 3));
            send_word(d, (w == nw - 1));
         end
         plan_end_frame();
         wait_reports(f + 1, ok);
      end
      for (int f = 0; f < nf; f++) begin
         n = (f < rep_cnt.size()) ? rep_cnt[f] : -1;
         n_checks++;
         if (n != exp_cnt(exp_n[f])) $display("FAIL rg_count%0d got %0d want %0d", f, n, exp_cnt(exp_n[f]));
         else n_pass++;
      end
      n_checks++;
      if (bits_match() !== 1'b1) $display("FAIL rg_bits got %0d bits want %0d matching", bits_q.size(), plan_bits.size());
      else n_pass++;
      n_checks++;
      if (clr_n != nf || clr_bad != 0)
         $display("FAIL rg_det_clr got %0d pulses %0d misaligned want %0d 0", clr_n, clr_bad, nf);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_reset_mid();
      test_cross_word();
      test_idle_gap();
      test_saturation();
      test_handshake();
      test_random_gaps();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller that sequences the serial 1011 sequence detector. It accepts parallel words over a valid/ready handshake and serialises them MSB-first onto the detector's `x` input, gating the detector with a clock enable. It counts detector hits (`z`) across a multi-word frame and reports the per-frame match count. It sits between the word-oriented datapath and the bit-serial detector, so the detector never needs a bit-level testbench-style driver.

## Interface
- `WIDTH`, default 8: bits per input word; must be ≥ 2.
- `CNT_W`, default 4: match counter width; the counter saturates at 2^CNT_W−1.

- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `in_valid`, input, 1: `in_data` and `in_last` are valid.
- `in_ready`, output, 1: controller can accept a word this cycle.
- `in_data`, input, WIDTH: word to scan; bit WIDTH−1 is sent first.
- `in_last`, input, 1: this word ends the frame.
- `det_x`, output, 1: serial bit to the detector's `x`.
- `det_en`, output, 1: detector clock enable; the detector advances only when this is 1.
- `det_clr`, output, 1: synchronous clear of the detector state, one-cycle pulse.
- `det_z`, input, 1: detector Moore output, reflecting all bits consumed on earlier enabled edges.
- `match_count`, output, CNT_W: matches in the last completed frame; held until the next report.
- `match_valid`, output, 1: one-cycle pulse; `match_count` and `overflow` are new.
- `overflow`, output, 1: last reported frame saturated the counter; updated with `match_valid`.

## Operation
- States: IDLE, SHIFT, DRAIN, REPORT.
- IDLE:
  - `in_ready`=1, `det_en`=0.
  - A transfer (`in_valid`&`in_ready`) loads the shift register, latches `in_last`, clears the bit index, and moves to SHIFT.
- SHIFT:
  - `det_en`=1 and `det_x`=shreg[WIDTH−1]; shift left once per cycle; index increments.
  - `in_ready`=1 only on the final bit cycle (index = WIDTH−1) and only if the current word is not last.
  - Final bit, not last, transfer occurs: reload and stay in SHIFT (gapless).
  - Final bit, not last, no transfer: go to IDLE.
  - Final bit, last: go to DRAIN.
- Counting:
  - `en_q` is `det_en` registered.
  - Each cycle with `en_q`=1 and `det_z`=1 increments the counter.
  - At 2^CNT_W−1 the counter holds and sets a sticky frame-overflow bit.
- DRAIN:
  - One cycle with `det_en`=0; the `det_z` for the final bit is counted here.
  - Go to REPORT.
- REPORT:
  - `match_count` ← counter and `overflow` ← frame-overflow, both in this cycle; `match_valid`=1; `det_clr`=1.
  - Counter and frame-overflow bit clear; go to IDLE.
- Detector state persists across word boundaries and IDLE gaps within a frame, so patterns spanning words are counted. It is cleared only by REPORT or `reset`.
- Reset (asynchronous, any state):
  - State IDLE; counter, index, shreg, frame-overflow, `en_q`, `match_count`, `overflow` all 0.
  - `det_x`, `det_en`, `det_clr`, `match_valid` = 0; `in_ready`=1 once in IDLE.
  - A partial frame is discarded with no `match_valid`. Reset deasserting mid-stream resumes in IDLE.

## Timing
- First word accepted on edge E0: bit k drives `det_x` in cycle E0+1+k.
- N-word frame, all words gapless: DRAIN in cycle E0+N·WIDTH+1; REPORT/`match_valid` in cycle E0+N·WIDTH+2.
- Earliest next-frame transfer is in the cycle after REPORT.
- Throughput: one bit per clock while words arrive gapless; each idle gap adds one IDLE cycle or more, with `det_en`=0.
- `in_ready` is combinational from state and index only. It never depends on `in_valid`.
- `in_data` is sampled only on a transfer edge. Changes at other times have no effect.

## Test plan
- **Single-word frame.** Reset, then word 8'b1011_0110 with `in_last`=1, overlapping 1011 detector model.
  - `det_x` sequence 1,0,1,1,0,1,1,0.
  - `match_valid` 10 cycles after acceptance, with `match_count`=2 and `overflow`=0.
- **Cross-word match.** 8'b0000_0101 then 8'b1000_0000 (last), back-to-back.
  - No `det_en` gap between the words.
  - `match_count`=1 (the pattern spans the boundary).
  - `match_valid` 18 cycles after the first acceptance.
- **Idle gap within a frame.** Same two words with `in_valid` low for 3 cycles between them.
  - `det_en`=0 for 4 cycles; `match_count` is still 1.
  - `match_valid` is delayed by 4 cycles.
- **Saturation.** 8 words of 8'b1011_0110, last on the 8th (16 matches).
  - `match_count`=15, `overflow`=1.
  - A following frame 8'b0000_0000 (last) reports 0 with `overflow`=0.
- **Reset mid-frame.** Assert `reset` during bit 5 of a non-last word.
  - All outputs are 0 immediately; no `match_valid`.
  - The next frame 8'b1011_0000 (last) reports 1.
- **Handshake.** Hold `in_valid`=1 throughout with varying data.
  - Exactly one transfer per WIDTH cycles.
  - `in_ready` is 0 in DRAIN and REPORT.
  - `det_clr` pulses exactly once per frame, coincident with `match_valid`.
